// File: rtl/cnn_tile_engine.sv
// Tiled fixed-point convolution layer: Tm_p x Tn_p MAC array swept over channel tiles and output pixels.
// Optional build macro CNN_TILE_RELU_EN applies max(acc,0) on fm_o; accumulators stay raw.
//
// state  | meaning
// S_IDLE | ready for a start request
// S_RUN  | one MAC step per cycle over j, i, c, r, tn-tile, tm-tile
// S_DONE | one-cycle done pulse, results stable on fm_o
module cnn_tile_engine #(
  parameter int N_p  = 4,
  parameter int M_p  = 4,
  parameter int K_p  = 2,
  parameter int R_p  = 4,
  parameter int C_p  = 4,
  parameter int S_p  = 1,
  parameter int Tn_p = 2,
  parameter int Tm_p = 2,
  parameter int DW_p = 8,
  localparam int AW_p = 2*DW_p + $clog2(N_p*K_p*K_p) + 1
) (
  input  logic                                                              clk_i,
  input  logic                                                              reset_i,
  input  logic                                                              valid_i,
  input  logic [N_p*((R_p-1)*S_p+K_p)*((C_p-1)*S_p+K_p)*DW_p-1:0]           fm_i,
  input  logic [M_p*N_p*K_p*K_p*DW_p-1:0]                                   weights_i,
  output logic                                                              ready_o,
  output logic                                                              valid_o,
  output logic [M_p*R_p*C_p*AW_p-1:0]                                       fm_o
);

  localparam int H_L  = (R_p-1)*S_p + K_p;
  localparam int W_L  = (C_p-1)*S_p + K_p;
  localparam int NACC = M_p*R_p*C_p;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state_q;
  logic                    valid_q;
  int                      j_q, i_q, c_q, r_q, nt_q, mt_q;
  logic signed [AW_p-1:0]  acc_q [NACC];
  logic signed [AW_p-1:0]  lane_sum_d [Tm_p];

  logic j_last, i_last, c_last, r_last, nt_last, mt_last, all_last;

  assign j_last   = (j_q == K_p-1);
  assign i_last   = (i_q == K_p-1);
  assign c_last   = (c_q == C_p-1);
  assign r_last   = (r_q == R_p-1);
  assign nt_last  = (nt_q + Tn_p >= N_p);
  assign mt_last  = (mt_q + Tm_p >= M_p);
  assign all_last = j_last & i_last & c_last & r_last & nt_last & mt_last;

  function automatic logic signed [AW_p-1:0] mac_term(input int m, input int n,
                                                       input int y, input int x,
                                                       input int i, input int j);
    logic signed [DW_p-1:0]   f;
    logic signed [DW_p-1:0]   w;
    logic signed [2*DW_p-1:0] p;
    f = fm_i[((n*H_L + y)*W_L + x)*DW_p +: DW_p];
    w = weights_i[(((m*N_p + n)*K_p + i)*K_p + j)*DW_p +: DW_p];
    p = f * w;
    return AW_p'(p);
  endfunction

  // Lanes past the last channel of a ragged tile are masked to zero.
  always_comb begin
    for (int a = 0; a < Tm_p; a++) begin
      lane_sum_d[a] = '0;
      for (int b = 0; b < Tn_p; b++) begin
        if ((mt_q + a < M_p) && (nt_q + b < N_p)) begin
          lane_sum_d[a] = lane_sum_d[a] + mac_term(mt_q + a, nt_q + b,
                                                   S_p*r_q + i_q, S_p*c_q + j_q,
                                                   i_q, j_q);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      j_q     <= 0;
      i_q     <= 0;
      c_q     <= 0;
      r_q     <= 0;
      nt_q    <= 0;
      mt_q    <= 0;
      for (int e = 0; e < NACC; e++) acc_q[e] <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            state_q <= S_RUN;
            j_q     <= 0;
            i_q     <= 0;
            c_q     <= 0;
            r_q     <= 0;
            nt_q    <= 0;
            mt_q    <= 0;
            for (int e = 0; e < NACC; e++) acc_q[e] <= '0;
          end
        end
        S_RUN: begin
          for (int a = 0; a < Tm_p; a++) begin
            if (mt_q + a < M_p) begin
              acc_q[((mt_q + a)*R_p + r_q)*C_p + c_q] <=
                acc_q[((mt_q + a)*R_p + r_q)*C_p + c_q] + lane_sum_d[a];
            end
          end
          j_q <= j_last ? 0 : j_q + 1;
          if (j_last) begin
            i_q <= i_last ? 0 : i_q + 1;
            if (i_last) begin
              c_q <= c_last ? 0 : c_q + 1;
              if (c_last) begin
                r_q <= r_last ? 0 : r_q + 1;
                if (r_last) begin
                  nt_q <= nt_last ? 0 : nt_q + Tn_p;
                  if (nt_last) mt_q <= mt_last ? 0 : mt_q + Tm_p;
                end
              end
            end
          end
          if (all_last) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Gated by reset so the engine never advertises readiness while being reset.
  assign ready_o = (state_q == S_IDLE) && !reset_i;
  assign valid_o = valid_q;

  for (genvar e = 0; e < NACC; e++) begin : g_out
`ifdef CNN_TILE_RELU_EN
    assign fm_o[e*AW_p +: AW_p] = acc_q[e][AW_p-1] ? '0 : acc_q[e];
`else
    assign fm_o[e*AW_p +: AW_p] = acc_q[e];
`endif
  end

endmodule
